// File: rtl/chip_if.sv
// Column-in / edge-out stream bundle of the edge-detection chip.
// The host (master) supplies one 5-row column per cycle; the chip (slave) returns edge magnitudes.
interface chip_if #(
  parameter int PW = 5
);
  logic [PW-1:0] pixel_in0;
  logic [PW-1:0] pixel_in1;
  logic [PW-1:0] pixel_in2;
  logic [PW-1:0] pixel_in3;
  logic [PW-1:0] pixel_in4;
  logic          load_end;
  logic [PW-1:0] edge_out;
  logic          readable;

  modport master (
    output pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4, load_end,
    input  edge_out, readable
  );

  modport slave (
    input  pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4, load_end,
    output edge_out, readable
  );
endinterface

// File: rtl/chip.sv
// Streaming edge detector: 5-column window, 3x3 Gaussian blur on rows 1..3,
// then a 3x3 Sobel centred on row 2; one registered magnitude per input column.
module chip #(
  parameter int PW = 5
) (
  input  logic clk,
  input  logic reset,
  chip_if.slave bus
);

  localparam int SW = PW + 5;
  localparam int GW = PW + 5;

  typedef enum logic [1:0] {LOAD, FLUSH, DONE} state_t;

  state_t        state_reg, state_next;
  logic          flush_cnt_reg, flush_cnt_next;
  logic [PW-1:0] col_in [0:4];
  logic          col_vld;

  // win_reg[0] is the newest column; win_reg[2] is the column being evaluated.
  logic [PW-1:0] win_reg [0:4][0:4];
  logic [2:0]    vld_reg;
  logic [PW-1:0] edge_reg, edge_next;
  logic          readable_reg;

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    col_vld        = 1'b0;
    for (int r = 0; r < 5; r++) col_in[r] = '0;
    case (state_reg)
      LOAD: begin
        col_in[0] = bus.pixel_in0;
        col_in[1] = bus.pixel_in1;
        col_in[2] = bus.pixel_in2;
        col_in[3] = bus.pixel_in3;
        col_in[4] = bus.pixel_in4;
        col_vld   = 1'b1;
        if (bus.load_end) begin
          state_next     = FLUSH;
          flush_cnt_next = 1'b0;
        end
      end
      FLUSH: begin
        flush_cnt_next = 1'b1;
        if (flush_cnt_reg) state_next = DONE;
      end
      default: begin
      end
    endcase
  end

  // Outside LOAD the window keeps shifting zero columns so the tail drains out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= LOAD;
      flush_cnt_reg <= 1'b0;
      vld_reg       <= '0;
      edge_reg      <= '0;
      readable_reg  <= 1'b0;
      for (int c = 0; c < 5; c++)
        for (int r = 0; r < 5; r++)
          win_reg[c][r] <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      for (int r = 0; r < 5; r++) begin
        win_reg[0][r] <= col_in[r];
        for (int c = 1; c < 5; c++) win_reg[c][r] <= win_reg[c-1][r];
      end
      vld_reg      <= {vld_reg[1:0], col_vld};
      readable_reg <= vld_reg[2];
      edge_reg     <= vld_reg[2] ? edge_next : '0;
    end
  end

  // Separable blur: vertical [1 2 1] per column, then horizontal [1 2 1].
  logic [SW-1:0] vsum [0:4][0:2];
  logic [PW-1:0] b_side [0:1][0:2];
  logic [PW-1:0] b_mid [0:1];

  genvar gi, gr;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_vcol
      for (gr = 0; gr < 3; gr++) begin : g_vrow
        assign vsum[gi][gr] = SW'(win_reg[gi][gr]) + (SW'(win_reg[gi][gr+1]) << 1)
                            + SW'(win_reg[gi][gr+2]);
      end
    end

    // b_side[0] is blurred column c+1, b_side[1] is column c-1; rows 1..3.
    for (gi = 0; gi < 2; gi++) begin : g_side
      localparam int CC = 1 + 2 * gi;
      for (gr = 0; gr < 3; gr++) begin : g_row
        logic [SW-1:0] hsum;
        assign hsum = vsum[CC-1][gr] + (vsum[CC][gr] << 1) + vsum[CC+1][gr];
        assign b_side[gi][gr] = PW'(hsum >> 4);
      end
    end

    // Centre column is only needed for rows 1 and 3 (Gy).
    for (gi = 0; gi < 2; gi++) begin : g_mid
      localparam int RR = 2 * gi;
      logic [SW-1:0] hsum;
      assign hsum = vsum[1][RR] + (vsum[2][RR] << 1) + vsum[3][RR];
      assign b_mid[gi] = PW'(hsum >> 4);
    end
  endgenerate

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay, mag;

  always_comb begin
    gx = GW'(b_side[0][0]) + (GW'(b_side[0][1]) << 1) + GW'(b_side[0][2])
       - GW'(b_side[1][0]) - (GW'(b_side[1][1]) << 1) - GW'(b_side[1][2]);
    gy = GW'(b_side[1][2]) + (GW'(b_mid[1]) << 1) + GW'(b_side[0][2])
       - GW'(b_side[1][0]) - (GW'(b_mid[0]) << 1) - GW'(b_side[0][0]);
    ax = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
    edge_next = PW'(mag >> 3);
  end

  assign bus.edge_out = edge_reg;
  assign bus.readable = readable_reg;

endmodule

// File: tb/tb_chip.sv
// Bench for chip: a column-level model of blur+Sobel with zero padding is checked
// against the DUT every cycle, plus hand-computed values for the directed strips.
module tb_chip;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  chip_if #(.PW(5)) bus ();
  chip #(.PW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int passes = 0;
  int img [0:15][0:4];
  int n_cols = 0;
  int got [0:15];
  int rd_count = 0;
  int edge_cnt = 0;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int pix(input int r, input int c);
    if (c < 0 || c >= n_cols) return 0;
    return img[c][r];
  endfunction

  function automatic int blur(input int r, input int c);
    int s;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * pix(r + dr, c + dc);
    return s / 16;
  endfunction

  function automatic int exp_edge(input int c);
    int gx, gy;
    gx = blur(1, c+1) + 2*blur(2, c+1) + blur(3, c+1)
       - blur(1, c-1) - 2*blur(2, c-1) - blur(3, c-1);
    gy = blur(3, c-1) + 2*blur(3, c) + blur(3, c+1)
       - blur(1, c-1) - 2*blur(1, c) - blur(1, c+1);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy) / 8;
  endfunction

  // Column 0 is captured on the first edge after reset release (edge_cnt becomes 1).
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    automatic int c = edge_cnt - 4;
    if (!reset) begin
      chk("reset_readable", int'(bus.readable), 0);
      chk("reset_edge", int'(bus.edge_out), 0);
    end else if (c >= 0 && c < n_cols) begin
      chk($sformatf("readable_col%0d", c), int'(bus.readable), 1);
      chk($sformatf("edge_col%0d", c), int'(bus.edge_out), exp_edge(c));
    end else begin
      chk($sformatf("idle_readable_t%0d", edge_cnt), int'(bus.readable), 0);
      chk($sformatf("idle_edge_t%0d", edge_cnt), int'(bus.edge_out), 0);
    end
    if (reset && bus.readable) begin
      rd_count++;
      if (c >= 0 && c < 16) got[c] = int'(bus.edge_out);
    end
  end

  task automatic set_col(input int k);
    bus.pixel_in0 = 5'(img[k][0]);
    bus.pixel_in1 = 5'(img[k][1]);
    bus.pixel_in2 = 5'(img[k][2]);
    bus.pixel_in3 = 5'(img[k][3]);
    bus.pixel_in4 = 5'(img[k][4]);
  endtask

  task automatic set_junk();
    bus.pixel_in0 = 5'($urandom_range(0, 31));
    bus.pixel_in1 = 5'($urandom_range(0, 31));
    bus.pixel_in2 = 5'($urandom_range(0, 31));
    bus.pixel_in3 = 5'($urandom_range(0, 31));
    bus.pixel_in4 = 5'($urandom_range(0, 31));
    bus.load_end  = 1'($urandom_range(0, 1));
  endtask

  // kind: 0 flat 20, 1 ramp, 2 vertical step at column 5, 3 horizontal step at row 2, else random
  task automatic run_strip(input int n, input int kind, input int abort_at);
    reset = 1'b0;
    set_junk();
    n_cols = n;
    rd_count = 0;
    for (int c = 0; c < 16; c++) got[c] = -1;
    for (int c = 0; c < n; c++)
      for (int r = 0; r < 5; r++)
        case (kind)
          0: img[c][r] = 20;
          1: img[c][r] = c;
          2: img[c][r] = (c >= 5) ? 16 : 0;
          3: img[c][r] = (r >= 2) ? 31 : 0;
          default: img[c][r] = int'($urandom_range(0, 31));
        endcase
    repeat (2) @(negedge clk);
    #2;
    set_col(0);
    bus.load_end = (n == 1);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k + 1 == abort_at) begin
        chk("pre_abort_readable", int'(bus.readable), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_readable", int'(bus.readable), 0);
        chk("abort_edge", int'(bus.edge_out), 0);
        return;
      end
      if (k + 1 < n) begin
        set_col(k + 1);
        bus.load_end = (k + 1 == n - 1);
      end else begin
        set_junk();
      end
    end
    repeat (8) begin
      @(posedge clk);
      #1;
      set_junk();
    end
    chk($sformatf("readable_cycles_n%0d", n), rd_count, n);
  endtask

  initial begin
    set_junk();

    run_strip(10, 0, 0);
    for (int c = 2; c <= 7; c++) chk($sformatf("flat_col%0d", c), got[c], 0);
    chk("flat_border0_nonzero", int'(got[0] > 0), 1);
    chk("flat_border9_nonzero", int'(got[9] > 0), 1);

    run_strip(10, 1, 0);
    for (int c = 2; c <= 7; c++) chk($sformatf("ramp_col%0d", c), got[c], 1);

    run_strip(12, 2, 0);
    chk("vstep_col4", got[4], 6);
    chk("vstep_col5", got[5], 6);
    chk("vstep_col1", got[1], 0);
    chk("vstep_col2", got[2], 0);
    for (int c = 7; c <= 9; c++) chk($sformatf("vstep_col%0d", c), got[c], 0);

    run_strip(8, 3, 0);
    chk("hstep_col3", got[3], 12);

    run_strip(1, 4, 0);

    run_strip(10, 1, 6);

    run_strip(12, 2, 0);
    chk("restart_vstep_col4", got[4], 6);

    run_strip(2, 4, 0);
    run_strip(6, 4, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
